// File: rtl/debug_bus_master.sv
// Single-outstanding debug bus master: takes one host command, strobes it onto a
// shared tri-state bus, waits for accept/available with timeouts, returns a response.
module debug_bus_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic [7:0]  bus_addr,
  output logic        bus_start,
  inout  wire  [63:0] bus_data,
  input  logic        bus_accepted,
  input  logic        bus_available,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and payload is held stable while valid && !ready.

  typedef enum logic [2:0] {IDLE, START, WAIT_ACC, WAIT_AVAIL, RESP} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    addr_q, addr_nxt;
  logic [63:0]   data_q, data_nxt;
  logic [63:0]   rdata_nxt;
  logic [1:0]    status_nxt;
  logic          bus_oe;
  logic          acc, avail;

  // Anything other than a clean 1 (X, Z, 0) is treated as not asserted.
  assign acc   = (bus_accepted === 1'b1);
  assign avail = (bus_available === 1'b1);

  assign bus_data  = bus_oe ? data_q : {64{1'bz}};
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = addr_q;
    data_nxt   = data_q;
    rdata_nxt  = rsp_data;
    status_nxt = rsp_status;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_nxt = cmd_addr;
          data_nxt = cmd_data;
          if (cmd_addr == 8'd0) begin
            state_nxt  = RESP;
            rdata_nxt  = 64'd0;
            status_nxt = 2'b11;
          end else begin
            state_nxt = START;
          end
        end
      end
      START: begin
        state_nxt = WAIT_ACC;
        cnt_nxt   = '0;
      end
      WAIT_ACC: begin
        // A device may skip the accept phase and answer straight away.
        if (avail) begin
          state_nxt  = RESP;
          rdata_nxt  = bus_data;
          status_nxt = 2'b00;
        end else if (acc) begin
          state_nxt = WAIT_AVAIL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = RESP;
          rdata_nxt  = 64'd0;
          status_nxt = 2'b01;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_AVAIL: begin
        if (avail) begin
          state_nxt  = RESP;
          rdata_nxt  = bus_data;
          status_nxt = 2'b00;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = RESP;
          rdata_nxt  = 64'd0;
          status_nxt = 2'b10;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change exactly on state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= 8'd0;
      data_q     <= 64'd0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 64'd0;
      rsp_status <= 2'b00;
      bus_addr   <= 8'd0;
      bus_start  <= 1'b0;
      bus_oe     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      cmd_ready  <= (state_nxt == IDLE);
      rsp_valid  <= (state_nxt == RESP);
      rsp_data   <= rdata_nxt;
      rsp_status <= status_nxt;
      bus_addr   <= (state_nxt inside {START, WAIT_ACC, WAIT_AVAIL}) ? addr_nxt : 8'd0;
      bus_start  <= (state_nxt == START);
      bus_oe     <= (state_nxt == START);
    end
  end

endmodule

// File: tb/tb_debug_bus_master.sv
// Directed bench for debug_bus_master with a small register-file responder on the bus.
module tb_debug_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [7:0]  cmd_addr, bus_addr;
  logic [63:0] cmd_data, rsp_data;
  logic [1:0]  rsp_status;
  logic        bus_start, bus_accepted, bus_available;
  logic [2:0]  dbg_state;
  wire  [63:0] bus_data;

  int tests  = 0;
  int failed = 0;
  logic [63:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  debug_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .bus_addr(bus_addr), .bus_start(bus_start), .bus_data(bus_data),
    .bus_accepted(bus_accepted), .bus_available(bus_available),
    .dbg_state(dbg_state)
  );

  // responder: mode 0 silent, 1 accept+available, 2 accept only, 3 available only
  int          mode = 0;
  logic        s1, s2, acc_r, avail_r;
  logic [63:0] cap, rval;
  logic [31:0] regs [16];
  logic        probe_en = 1'b0;
  logic [63:0] probe_val = 64'hA5A5_5A5A_0F0F_F0F0;

  assign bus_data      = avail_r ? rval : (probe_en ? probe_val : {64{1'bz}});
  assign bus_accepted  = acc_r;
  assign bus_available = avail_r;

  always @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; acc_r <= 1'b0; avail_r <= 1'b0;
    end else begin
      s1      <= bus_start && (mode != 0);
      s2      <= s1;
      acc_r   <= s1 && (mode == 1 || mode == 2);
      avail_r <= (s2 && mode == 1) || (s1 && mode == 3);
      if (bus_start) cap <= bus_data;
      if (s1) begin
        if (cap[0]) begin
          regs[cap[4:1]] <= cap[63:32];
          rval <= 64'd1;
        end else begin
          rval <= {32'd0, regs[cap[4:1]]};
        end
      end
    end
  end

  // comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // per-command observations
  logic [63:0] r_data, r_start_data;
  logic [7:0]  r_start_addr;
  logic [1:0]  r_status;
  int          r_lat, r_starts;
  logic        r_hold_ok, r_z_ok;

  task automatic do_cmd(input logic [7:0] a, input logic [63:0] d);
    int k;
    logic got;
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    r_starts = 0; r_hold_ok = 1'b1; r_z_ok = 1'b1; got = 1'b0; r_lat = -1;
    r_start_data = 64'd0; r_start_addr = 8'd0;
    for (k = 0; k < 40; k++) begin
      if (bus_start) begin
        r_starts++; r_start_data = bus_data; r_start_addr = bus_addr;
      end else if (probe_en && bus_data !== probe_val) begin
        r_z_ok = 1'b0;
      end
      if (rsp_valid) begin got = 1'b1; r_lat = k; break; end
      if (bus_addr !== a) r_hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("rsp_valid_seen", {63'd0, got}, 64'd1);
    r_data = rsp_data; r_status = rsp_status;
  endtask

  task automatic take_rsp();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable_ok;
    logic [63:0] hold_data;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    cmd_valid = 1'b0; cmd_addr = 8'd0; cmd_data = 64'd0; rsp_ready = 1'b0;
    probe_en = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_status", {62'd0, rsp_status}, 64'd0);
    chk("rst_bus_addr", {56'd0, bus_addr}, 64'd0);
    chk("rst_bus_start", {63'd0, bus_start}, 64'd0);
    chk("rst_bus_data_z", bus_data, probe_val);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    probe_en = 1'b0;

    // write reg 3 = DEADBEEF
    mode = 1;
    exp_q.push_back(64'd1);
    do_cmd(8'd1, {32'hDEADBEEF, 27'b0, 4'd3, 1'b1});
    chk("wr_start_cycles", 64'(r_starts), 64'd1);
    chk("wr_start_data", r_start_data, {32'hDEADBEEF, 27'b0, 4'd3, 1'b1});
    chk("wr_start_addr", {56'd0, r_start_addr}, 64'd1);
    chk("wr_addr_hold", {63'd0, r_hold_ok}, 64'd1);
    chk("wr_latency", 64'(r_lat), 64'd4);
    chk("wr_status", {62'd0, r_status}, 64'd0);
    chk("wr_data", r_data, exp_q.pop_front());
    chk("wr_resp_bus_addr", {56'd0, bus_addr}, 64'd0);
    take_rsp();

    // read reg 3, then stall the response for 10 cycles
    exp_q.push_back(64'h00000000DEADBEEF);
    do_cmd(8'd1, 64'h6);
    chk("rd_latency", 64'(r_lat), 64'd4);
    chk("rd_status", {62'd0, r_status}, 64'd0);
    hold_data = exp_q.pop_front();
    chk("rd_data", r_data, hold_data);
    stable_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== hold_data || rsp_status !== 2'b00 || cmd_ready)
        stable_ok = 1'b0;
    end
    chk("stall_stable", {63'd0, stable_ok}, 64'd1);
    take_rsp();
    chk("after_take_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("after_take_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // device answers without an accept phase
    mode = 3;
    do_cmd(8'd2, 64'h6);
    chk("avonly_latency", 64'(r_lat), 64'd3);
    chk("avonly_status", {62'd0, r_status}, 64'd0);
    chk("avonly_data", r_data, 64'h00000000DEADBEEF);
    take_rsp();

    // no responder: accept timeout
    mode = 0; probe_en = 1'b1;
    do_cmd(8'd5, 64'h0123_4567_89AB_CDEF);
    chk("acc_to_latency", 64'(r_lat), 64'd17);
    chk("acc_to_status", {62'd0, r_status}, 64'd1);
    chk("acc_to_data", r_data, 64'd0);
    chk("acc_to_bus_z", {63'd0, r_z_ok}, 64'd1);
    chk("acc_to_addr_hold", {63'd0, r_hold_ok}, 64'd1);
    chk("acc_to_bus_addr", {56'd0, bus_addr}, 64'd0);
    take_rsp();

    // accepted but never available
    mode = 2;
    do_cmd(8'd9, 64'h6);
    chk("av_to_latency", 64'(r_lat), 64'd19);
    chk("av_to_status", {62'd0, r_status}, 64'd2);
    chk("av_to_data", r_data, 64'd0);
    chk("av_to_addr_hold", {63'd0, r_hold_ok}, 64'd1);
    take_rsp();
    probe_en = 1'b0;

    // reserved address 0
    mode = 1;
    do_cmd(8'd0, 64'hFFFF_0000_FFFF_0000);
    chk("bad_latency", 64'(r_lat), 64'd0);
    chk("bad_status", {62'd0, r_status}, 64'd3);
    chk("bad_data", r_data, 64'd0);
    chk("bad_no_start", 64'(r_starts), 64'd0);
    // a command offered on the take edge must not be accepted
    @(negedge clk); rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = 8'd0;
    @(posedge clk); #1; rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("take_edge_no_accept", {63'd0, rsp_valid}, 64'd0);
    chk("take_edge_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // reset in WAIT_ACC
    mode = 0; probe_en = 1'b1;
    @(negedge clk); cmd_valid = 1'b1; cmd_addr = 8'd7; cmd_data = 64'h77;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_bus_addr", {56'd0, bus_addr}, 64'd7);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_bus_addr", {56'd0, bus_addr}, 64'd0);
    chk("mid_rst_bus_start", {63'd0, bus_start}, 64'd0);
    chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_bus_z", bus_data, probe_val);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    probe_en = 1'b0; mode = 1;
    do_cmd(8'd1, 64'h6);
    chk("post_rst_latency", 64'(r_lat), 64'd4);
    chk("post_rst_data", r_data, 64'h00000000DEADBEEF);
    chk("post_rst_status", {62'd0, r_status}, 64'd0);
    take_rsp();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/debug_bus_master.md
DEBUG_BUS_MASTER -- requirements
Module: debug_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max wait cycles in each of WAIT_ACC and WAIT_AVAIL before abort.
REQ-002 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  host request present.
REQ-005 SHALL have port cmd_ready  out  1  master can take a request.
REQ-006 SHALL have port cmd_addr  in  8  target device address; 0 reserved as "no device".
REQ-007 SHALL have port cmd_data  in  64  request payload, passed to the device unmodified.
REQ-008 SHALL have port rsp_valid  out  1  response present.
REQ-009 SHALL have port rsp_ready  in  1  host takes response.
REQ-010 SHALL have port rsp_data  out  64  value captured from bus_data, or 0 on error.
REQ-011 SHALL have port rsp_status  out  2  00 ok, 01 accept timeout, 10 available timeout, 11 bad address.
REQ-012 SHALL have port bus_addr  out  8  device select; 0 when idle.
REQ-013 SHALL have port bus_start  out  1  one-cycle request strobe.
REQ-014 SHALL have port bus_data  inout  64  driven by master only in START; high-Z otherwise.
REQ-015 SHALL have port bus_accepted  in  1  device took request; any value other than 1 counts as 0.
REQ-016 SHALL have port bus_available  in  1  device response valid on bus_data this cycle; any value other than 1 counts as 0.

Function
REQ-017 SHALL implement states IDLE, START, WAIT_ACC, WAIT_AVAIL, RESP; all bus outputs registered.
REQ-018 SHALL assert cmd_ready only in IDLE; handshake is cmd_valid && cmd_ready at a rising edge.
REQ-019 SHALL, on handshake with cmd_addr != 0, latch addr/data and go to START.
REQ-020 SHALL, on handshake with cmd_addr == 0, go to RESP with rsp_status 11 and rsp_data 0, with no bus activity.
REQ-021 SHALL, in START (exactly one cycle), drive bus_addr=latched addr, bus_start=1, bus_data=latched data, then go to WAIT_ACC.
REQ-022 SHALL hold bus_addr at the latched address from START through the last WAIT_AVAIL cycle; bus_start=0 and bus_data=Z outside START.
REQ-023 SHALL, in WAIT_ACC, go to WAIT_AVAIL when bus_accepted=1.
REQ-024 SHALL, in WAIT_ACC, treat bus_available=1 (with or without accepted) as completion: capture bus_data, go to RESP, status 00.
REQ-025 SHALL, in WAIT_AVAIL, capture bus_data into rsp_data when bus_available=1, go to RESP, status 00.
REQ-026 SHALL clear the wait counter on entry to WAIT_ACC and to WAIT_AVAIL; abort after TIMEOUT_CYCLES cycles in that state without the awaited signal, go to RESP with status 01 or 10 and rsp_data 0.
REQ-027 SHALL set bus_addr=0 on every entry to RESP.
REQ-028 SHALL assert rsp_valid throughout RESP; hold rsp_data/rsp_status stable until rsp_valid && rsp_ready; then go to IDLE.
REQ-029 SHALL not accept a new command in the cycle the response is taken; the earliest next handshake is one cycle later.
REQ-030 SHALL give ok latency of 4 cycles from handshake edge to rsp_valid high against a responder that asserts accepted 1 cycle and available 2 cycles after its start sample.

Reset
REQ-031 SHALL, while rst=1, force IDLE, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_status=00, bus_addr=0, bus_start=0, bus_data=Z, counter=0.
REQ-032 SHALL, on rst mid-transaction, abandon it with no response; cmd_ready=1 on the first cycle after rst falls.

Verification
REQ-033 SHALL verify: write cmd addr 1, data {32'hDEADBEEF,27'b0,4'd3,1'b1}, with regfile responder -> START one cycle with that data on bus, rsp_data=1, status 00, 4 cycles after handshake; then read reg 3 (data 64'h6) -> rsp_data=64'h00000000DEADBEEF.
REQ-034 SHALL verify: cmd addr 5, no responder -> bus_data Z after START, status 01 after 16 WAIT_ACC cycles, rsp_data 0, bus_addr 0.
REQ-035 SHALL verify: responder accepts but never asserts available -> status 10 after 16 WAIT_AVAIL cycles.
REQ-036 SHALL verify: cmd addr 0 -> rsp_valid next cycle, status 11, bus_start never high.
REQ-037 SHALL verify: rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, cmd_ready 0; then rsp_ready=1 -> IDLE, cmd_ready high 1 cycle later.
REQ-038 SHALL verify: rst pulsed during WAIT_ACC -> bus_addr 0, bus_start 0, bus_data Z, rsp_valid 0 next cycle; a following command completes normally.
